// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - Fetch/execute sequencer driving PC strobes; PC_SEQ_HALT_DETECT_EN enables self-jump halt detection
module pc_sequencer #(
    parameter int ADDR_W        = 16,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_q,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic              zr,
    input  logic              ng,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic              pc_reset,
    output logic              pc_load,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_in,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_FETCH, S_EXEC, S_HALT, S_ERROR
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] wait_cnt;
    logic       jump;
    logic       self_jump;

    assign jump = instr[15] & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~zr & ~ng));

`ifdef PC_SEQ_HALT_DETECT_EN
    assign self_jump = jump & (a_reg == pc_q);
`else
    assign self_jump = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    // wait_cnt is held at zero outside FETCH so every fetch starts a fresh count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            instr    <= '0;
        end else begin
            if (state != S_FETCH) begin
                wait_cnt <= '0;
            end else if (!imem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == S_FETCH && imem_ack) begin
                instr <= imem_data;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:  state_nx = S_IDLE;
            S_IDLE:  if (run) state_nx = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    state_nx = S_EXEC;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = S_ERROR;
                end
            end
            S_EXEC: begin
                if (self_jump) begin
                    state_nx = S_HALT;
                end else if (run) begin
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_HALT:  if (!run) state_nx = S_IDLE;
            S_ERROR: state_nx = S_ERROR;
            default: state_nx = S_ERROR;
        endcase
    end

    always_comb begin
        imem_req    = (state == S_FETCH);
        imem_addr   = imem_req ? pc_q : '0;
        instr_valid = (state == S_EXEC);
        pc_reset    = (state == S_INIT);
        pc_load     = (state == S_EXEC) & jump & ~self_jump;
        pc_inc      = (state == S_EXEC) & ~jump;
        pc_in       = pc_load ? a_reg : '0;
        busy        = (state == S_FETCH) | (state == S_EXEC);
        error       = (state == S_ERROR);
`ifdef PC_SEQ_HALT_DETECT_EN
        halted      = (state == S_HALT);
`else
        halted      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - Self-checking bench for pc_sequencer against a behavioural PC/instruction model
module tb_pc_sequencer;

    localparam int AW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic [AW-1:0] pc_q = '0;
    logic [AW-1:0] a_reg = '0;
    logic          zr = 1'b0;
    logic          ng = 1'b0;
    logic          imem_ack = 1'b0;
    logic [15:0]   imem_data = '0;

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [15:0]   instr;
    logic          instr_valid;
    logic          pc_reset;
    logic          pc_load;
    logic          pc_inc;
    logic [AW-1:0] pc_in;
    logic          busy;
    logic          halted;
    logic          error;
    logic [7:0]    status;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] pc = '0;

    pc_sequencer #(.ADDR_W(AW), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .pc_q(pc_q), .a_reg(a_reg),
        .zr(zr), .ng(ng), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr),
        .instr_valid(instr_valid), .pc_reset(pc_reset), .pc_load(pc_load),
        .pc_inc(pc_inc), .pc_in(pc_in), .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    // {pc_reset, pc_load, pc_inc, imem_req, instr_valid, busy, halted, error}
    assign status = {pc_reset, pc_load, pc_inc, imem_req, instr_valid, busy, halted, error};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_status", status, 8'b1000_0000);
        check("rst_instr", instr, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_pc_in", pc_in, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("init_pulse", status, 8'b1000_0000);
        @(negedge clk);
        #1 check("idle_after_init", status, 8'b0000_0000);
        pc = '0;
        pc_q = '0;
    endtask

    // Entered at a point where the DUT sits in FETCH; models one whole instruction.
    task automatic run_instr(input logic [15:0] iw, input int waits, input logic [1:0] cls,
                             input logic [AW-1:0] a, input bit run_after, input bit run_mid,
                             output bit halt);
        bit taken;
        pc_q = pc;
        for (int w = 0; w <= waits; w++) begin
            #1;
            check("fetch_status", status, 8'b0001_0100);
            check("fetch_addr", imem_addr, pc);
            if (w == waits) begin
                imem_ack  = 1'b1;
                imem_data = iw;
            end else begin
                imem_ack  = 1'b0;
                imem_data = 16'($urandom);
                run       = run_mid;
            end
            @(negedge clk);
        end
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        // cls: 0 = ALU result positive, 1 = zero, 2 = negative; jump bits are {lt, eq, gt}
        zr    = (cls == 2'd1);
        ng    = (cls == 2'd2);
        a_reg = a;
        run   = run_after;
        taken = iw[15] && iw[cls];
        halt  = 1'b0;
`ifdef PC_SEQ_HALT_DETECT_EN
        halt  = taken && (a == pc);
`endif
        #1;
        check("exec_instr", instr, iw);
        check("exec_status", status, {1'b0, taken && !halt, !taken, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        check("exec_pc_in", pc_in, (taken && !halt) ? a : '0);
        if (!halt) pc = taken ? a : pc + 16'd1;
        @(negedge clk);
        pc_q = pc;
        #1;
        if (halt) check("halt_status", status, 8'b0000_0010);
        else if (!run_after) check("idle_status", status, 8'b0000_0000);
    endtask

    // Brings the DUT back to FETCH after an instruction that ended in HALT or IDLE.
    task automatic resume(input bit h, input bit ra);
        if (h) begin
            if (ra) begin
                @(negedge clk);
                #1 check("halt_hold", status, 8'b0000_0010);
                run = 1'b0;
            end
            @(negedge clk);
            #1 check("halt_exit", status, 8'b0000_0000);
            run = 1'b1;
            @(negedge clk);
        end else if (!ra) begin
            @(negedge clk);
            #1 check("idle_hold", status, 8'b0000_0000);
            run = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0]   iw;
        logic [1:0]    cls;
        logic [AW-1:0] a;
        bit            ra;
        bit            h;

        do_reset();
        @(negedge clk);
        #1 check("idle_no_run", status, 8'b0000_0000);
        run = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) run_instr(16'h0010, 0, 2'd0, 16'h1234, 1'b1, 1'b1, h);
        run_instr(16'hE302, 0, 2'd1, 16'h0040, 1'b1, 1'b1, h);
        run_instr(16'hE302, 0, 2'd0, 16'h0040, 1'b1, 1'b1, h);
        run_instr(16'h0010, TO - 1, 2'd0, 16'h0000, 1'b1, 1'b0, h);

        run_instr(16'hEA87, 0, 2'd0, 16'h0005, 1'b1, 1'b1, h);
        run_instr(16'hEA87, 0, 2'd0, 16'h0005, 1'b1, 1'b1, h);
        resume(h, 1'b1);

        for (int k = 0; k < 40; k++) begin
            iw = 16'($urandom);
            if ($urandom_range(0, 1) == 1) iw[15] = 1'b1;
            cls = 2'($urandom_range(0, 2));
            a   = ($urandom_range(0, 3) == 0) ? pc : AW'($urandom);
            ra  = ($urandom_range(0, 3) != 0);
            run_instr(iw, int'($urandom_range(0, TO - 1)), cls, a, ra, 1'($urandom), h);
            resume(h, ra);
        end

        pc_q = pc;
        imem_ack = 1'b0;
        for (int w = 0; w < TO; w++) begin
            #1 check("to_fetch", status, 8'b0001_0100);
            @(negedge clk);
        end
        #1 check("to_error", status, 8'b0000_0001);
        imem_ack = 1'b1;
        run = 1'b1;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            #1 check("error_sticky", status, 8'b0000_0001);
        end
        imem_ack = 1'b0;
        run = 1'b0;

        do_reset();
        run = 1'b1;
        @(negedge clk);
        pc_q = 16'h0077;
        #1 check("pre_rst_fetch", status, 8'b0001_0100);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_fetch", status, 8'b1000_0000);
        check("rst_mid_addr", imem_addr, 0);
        @(negedge clk);
        imem_ack  = 1'b1;
        imem_data = 16'hFFFF;
        reset     = 1'b1;
        @(negedge clk);
        #1;
        check("late_ack_idle", status, 8'b0000_0000);
        check("late_ack_instr", instr, 0);
        imem_ack = 1'b0;
        pc   = '0;
        pc_q = '0;
        @(negedge clk);
        run_instr(16'h0010, 0, 2'd0, 16'h0000, 1'b0, 1'b1, h);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: ADDR_W, 16, width of PC, A-register and instruction-memory address.
REQ-002 Parameter: FETCH_TIMEOUT, 255, max wait cycles for imem_ack before ERROR (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; 1 = execute, 0 = stop after the current instruction.
REQ-006 pc_q  input  ADDR_W  current PC register value.
REQ-007 a_reg  input  ADDR_W  A register, the jump target.
REQ-008 zr, ng  input  1 each  ALU zero/negative flags, valid combinationally in EXEC.
REQ-009 imem_req  output  1  fetch request; imem_addr  output  ADDR_W  fetch address.
REQ-010 imem_ack  input  1  fetch complete; imem_data  input  16  fetched instruction, valid with ack.
REQ-011 instr  output  16  latched instruction; instr_valid  output  1  high for the single EXEC cycle.
REQ-012 pc_reset, pc_load, pc_inc  output  1 each  PC control strobes; pc_in  output  ADDR_W  PC load value.
REQ-013 busy, halted, error  output  1 each  status flags.

Function
REQ-014 States SHALL be INIT, IDLE, FETCH, EXEC, HALT, ERROR.
REQ-015 INIT: pc_reset=1 for exactly one cycle, then IDLE.
REQ-016 IDLE: all strobes 0; run=1 -> FETCH next cycle.
REQ-017 FETCH: imem_req=1, imem_addr=pc_q, held stable until the ack cycle.
REQ-018 FETCH: imem_ack=1 -> instr<=imem_data, EXEC next cycle; the wait counter clears on FETCH entry.
REQ-019 FETCH: FETCH_TIMEOUT consecutive cycles without ack -> ERROR; an ack on the last allowed cycle SHALL be accepted.
REQ-020 EXEC: instr_valid=1 for one cycle.
REQ-021 EXEC jump condition: instr[15] & ((instr[2]&ng) | (instr[1]&zr) | (instr[0]&~zr&~ng)).
REQ-022 EXEC, jump taken: pc_load=1, pc_in=a_reg; not taken: pc_inc=1; exactly one strobe per EXEC.
REQ-023 pc_load, pc_inc and pc_reset SHALL be mutually exclusive and 0 outside INIT/EXEC.
REQ-024 After EXEC: run=1 -> FETCH, run=0 -> IDLE; minimum throughput is one instruction per 2 cycles with 0-wait ack.
REQ-025 run falling during FETCH SHALL NOT abort the fetch; the instruction completes.
REQ-026 ERROR: sticky, error=1, all strobes 0, exit only by reset.
REQ-027 busy=1 in FETCH and EXEC, else 0; pc_in SHALL be 0 when pc_load=0.

Reset
REQ-028 reset=0 SHALL immediately force state INIT, instr=0, wait counter=0, and all outputs 0 except pc_reset=1.
REQ-029 Reset mid-FETCH SHALL drop imem_req asynchronously; a late ack after release SHALL be ignored.

Configuration
REQ-030 With macro PC_SEQ_HALT_DETECT_EN defined: a taken jump in EXEC with a_reg==pc_q SHALL assert no strobe and enter HALT; halted=1.
REQ-031 In HALT: stay while run=1; run=0 -> IDLE with halted cleared.
REQ-032 Without the macro: HALT is unreachable, halted is tied 0, and self-jumps load the PC normally.

Verification
REQ-033 Reset release -> one pc_reset pulse, then IDLE; all other strobes 0.
REQ-034 run=1, instr 0x0010 (A-instr), ack after 0 waits -> pc_inc once per 2 cycles, pc_in=0.
REQ-035 instr 0xE302 (D;JEQ), zr=1, a_reg=0x0040 -> pc_load=1, pc_in=0x0040; with zr=0 -> pc_inc=1.
REQ-036 imem_ack held 0 for FETCH_TIMEOUT=4 cycles -> error=1 and stuck until reset; ack on 4th cycle -> EXEC.
REQ-037 Macro on, 0xEA87 (0;JMP), a_reg=pc_q=0x0005 -> halted=1, no strobe; run=0 -> IDLE. Macro off -> pc_load=1.
REQ-038 reset asserted during FETCH wait -> imem_req=0 immediately; restart fetches from PC 0.
